mfcc_frame_addr_ctrl: RTL

Sequencer for the MFCC front-end's 12-bit sample-address generator: it issues the generator's 2-bit command and value each cycle so the generated address walks overlapping analysis frames (FRAME_LEN samples per frame, HOP samples between frame starts) for a programmed number of frames. It sits between the frame-level control FSM and the sample-buffer read path. It produces a latency-aligned valid strobe and an expected-address shadow so the buffer read and the bench both know which generated addresses are real samples.

---
 rtl/mfcc_frame_addr_ctrl_if.sv | 40 ++++
 rtl/mfcc_frame_addr_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_frame_addr_ctrl_if.sv
// rtl/mfcc_frame_addr_ctrl_if.sv - control and generator-command bundle for the MFCC frame address sequencer
//
// Purpose: groups the sequencer's control handshake (start/num_frames/abort/busy/done),
// the sample-buffer read qualifier (rd_ready) and the address-generator command and
// shadow outputs.
// Ports (signals):
//   start, num_frames, abort, rd_ready            : driven by the controlling side (master)
//   addr_sel, addr_value                          : generator command from the sequencer
//   addr_valid, addr_exp, frame_first, frame_last : latency-aligned sample qualifier and shadow
//   busy, done                                    : job status
// Modports: master = frame-level controller side, slave = sequencer.

interface mfcc_frame_addr_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic [7:0]            num_frames;
    logic                  abort;
    logic                  rd_ready;
    logic [1:0]            addr_sel;
    logic [ADDR_WIDTH-1:0] addr_value;
    logic                  addr_valid;
    logic [ADDR_WIDTH-1:0] addr_exp;
    logic                  frame_first;
    logic                  frame_last;
    logic                  busy;
    logic                  done;

    modport master (
        output start, num_frames, abort, rd_ready,
        input  addr_sel, addr_value, addr_valid, addr_exp,
        input  frame_first, frame_last, busy, done
    );

    modport slave (
        input  start, num_frames, abort, rd_ready,
        output addr_sel, addr_value, addr_valid, addr_exp,
        output frame_first, frame_last, busy, done
    );
endinterface

// File: rtl/mfcc_frame_addr_ctrl.sv
// rtl/mfcc_frame_addr_ctrl.sv - command sequencer walking overlapping MFCC analysis frames
//
// Purpose: drives the 2-bit command / addend of the 12-bit sample-address generator so
// that its output walks num_frames frames of FRAME_LEN samples, frame starts HOP apart.
// A shadow copy of the generator address and a valid pipeline ADDR_LAT deep tell the
// read path which generator outputs are real samples.
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   bus.start / bus.num_frames : job request, accepted only while idle
//   bus.abort  : synchronous abort, overrides everything else
//   bus.rd_ready : a sample may be issued this cycle
//   bus.addr_sel / bus.addr_value : registered generator command (00 clr, 01 +1, 10 +value, 11 hold)
//   bus.addr_valid / bus.addr_exp / bus.frame_first / bus.frame_last : aligned sample info
//   bus.busy / bus.done : job status and one-cycle completion pulse

module mfcc_frame_addr_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int FRAME_LEN  = 400,
    parameter int HOP        = 160,
    parameter int ADDR_LAT   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mfcc_frame_addr_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam int DW = (ADDR_LAT > 1) ? $clog2(ADDR_LAT) : 1;

    localparam logic [1:0] SEL_CLR  = 2'b00;
    localparam logic [1:0] SEL_INC  = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] LAST_CNT   = ADDR_WIDTH'(FRAME_LEN - 1);
    // Going from the last sample of a frame to the next frame start is a step of
    // HOP-(FRAME_LEN-1); negative values wrap, which the generator's modulo add absorbs.
    localparam logic [ADDR_WIDTH-1:0] JUMP       = ADDR_WIDTH'(HOP - FRAME_LEN + 1);
    localparam logic [DW-1:0]         DRAIN_LAST = DW'(ADDR_LAT - 1);

    state_t                  state_q, state_d;
    logic [1:0]              sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   value_q, value_d;
    logic [ADDR_WIDTH-1:0]   shadow_q, shadow_d;
    logic [ADDR_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;
    logic [7:0]              frame_cnt_q, frame_cnt_d;
    logic [7:0]              nf_q, nf_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    issue;
    logic                    flush;

    logic                    pipe_valid_q [ADDR_LAT];
    logic                    pipe_valid_d [ADDR_LAT];
    logic [ADDR_WIDTH-1:0]   pipe_addr_q  [ADDR_LAT];
    logic [ADDR_WIDTH-1:0]   pipe_addr_d  [ADDR_LAT];
    logic                    pipe_first_q [ADDR_LAT];
    logic                    pipe_first_d [ADDR_LAT];
    logic                    pipe_last_q  [ADDR_LAT];
    logic                    pipe_last_d  [ADDR_LAT];

    // ------------------------------------------------------------------
    // State and command registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sel_q        <= SEL_HOLD;
            value_q      <= '0;
            shadow_q     <= '0;
            sample_cnt_q <= '0;
            frame_cnt_q  <= '0;
            nf_q         <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            value_q      <= value_d;
            shadow_q     <= shadow_d;
            sample_cnt_q <= sample_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            nf_q         <= nf_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and command decode. Everything computed here is the value
    // that appears on the ports in the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sel_d        = SEL_HOLD;
        value_d      = '0;
        shadow_d     = shadow_q;
        sample_cnt_d = sample_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        nf_d         = nf_q;
        drain_d      = drain_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        issue        = 1'b0;
        flush        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    nf_d = bus.num_frames;
                    if (bus.num_frames != 8'd0) begin
                        state_d = S_CLEAR;
                        sel_d   = SEL_CLR;
                        busy_d  = 1'b1;
                    end else begin
                        // Empty job: straight to completion without touching the generator.
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            S_CLEAR: begin
                shadow_d     = '0;
                sample_cnt_d = '0;
                frame_cnt_d  = '0;
                state_d      = S_RUN;
            end

            S_RUN: begin
                if (bus.rd_ready) begin
                    // The sample issued now is the shadow address before this command.
                    issue = 1'b1;
                    if (sample_cnt_q != LAST_CNT) begin
                        sel_d        = SEL_INC;
                        shadow_d     = shadow_q + 1'b1;
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end else if (frame_cnt_q != (nf_q - 8'd1)) begin
                        sel_d        = SEL_ADD;
                        value_d      = JUMP;
                        shadow_d     = shadow_q + JUMP;
                        sample_cnt_d = '0;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end

            S_DRAIN: begin
                // Wait out the generator latency so done lands one cycle after the last valid.
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any decision above, including a same-cycle start.
        if (bus.abort) begin
            state_d = S_IDLE;
            sel_d   = SEL_CLR;
            value_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            issue   = 1'b0;
            flush   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Valid / shadow pipeline: stage 0 captures an issued sample, the last
    // stage lines up with the generator output ADDR_LAT cycles later.
    // ------------------------------------------------------------------
    always_comb begin
        pipe_valid_d = '{default: 1'b0};
        pipe_addr_d  = '{default: '0};
        pipe_first_d = '{default: 1'b0};
        pipe_last_d  = '{default: 1'b0};

        if (!flush) begin
            pipe_valid_d[0] = issue;
            pipe_addr_d[0]  = issue ? shadow_q : '0;
            pipe_first_d[0] = issue && (sample_cnt_q == '0);
            pipe_last_d[0]  = issue && (sample_cnt_q == LAST_CNT);
            for (int i = 1; i < ADDR_LAT; i++) begin
                pipe_valid_d[i] = pipe_valid_q[i-1];
                pipe_addr_d[i]  = pipe_addr_q[i-1];
                pipe_first_d[i] = pipe_first_q[i-1];
                pipe_last_d[i]  = pipe_last_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_q <= '{default: 1'b0};
            pipe_addr_q  <= '{default: '0};
            pipe_first_q <= '{default: 1'b0};
            pipe_last_q  <= '{default: 1'b0};
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_addr_q  <= pipe_addr_d;
            pipe_first_q <= pipe_first_d;
            pipe_last_q  <= pipe_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign bus.addr_sel    = sel_q;
    assign bus.addr_value  = value_q;
    assign bus.addr_valid  = pipe_valid_q[ADDR_LAT-1];
    assign bus.addr_exp    = pipe_addr_q[ADDR_LAT-1];
    assign bus.frame_first = pipe_first_q[ADDR_LAT-1];
    assign bus.frame_last  = pipe_last_q[ADDR_LAT-1];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
